// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard unit: select encoding,
// latency codes and the shadow-pipeline entry layout.
package fwd_pkg;

  localparam int SEL_FORWARD_RAW = 0;

  // Entry fields are sized for the widest supported configuration
  localparam int ENTRY_RD_W  = 8;
  localparam int ENTRY_LAT_W = 4;

  localparam logic [ENTRY_LAT_W-1:0] LAT_ALU  = 4'd1;
  localparam logic [ENTRY_LAT_W-1:0] LAT_LOAD = 4'd2;

  typedef struct packed {
    logic                   valid;
    logic [ENTRY_RD_W-1:0]  rd;
    logic [ENTRY_LAT_W-1:0] lat;
  } fwd_entry_t;

  // Forwarding from stage k is encoded as select value k
  function automatic int stage_sel(input int k);
    return k;
  endfunction

  function automatic logic [ENTRY_LAT_W-1:0] clamp_lat(input logic [ENTRY_LAT_W-1:0] lat,
                                                       input logic [ENTRY_LAT_W-1:0] depth);
    logic [ENTRY_LAT_W-1:0] res;
    if (lat == 4'd0) begin
      res = LAT_ALU;
    end else if (lat > depth) begin
      res = depth;
    end else begin
      res = lat;
    end
    return res;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// EX-side bus of the forwarding/hazard unit; master is the pipeline, slave is the unit.
interface fwd_hazard_unit_if #(
  parameter int NUM_RD    = 2,
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
);
  logic                     ex_valid;
  logic                     ex_we;
  logic [REG_AW-1:0]        ex_rd;
  logic [SEL_W-1:0]         ex_lat;
  logic [NUM_RD*REG_AW-1:0] ex_src;
  logic                     flush;
  logic [NUM_RD*SEL_W-1:0]  fwd_sel;
  logic                     stall;
  logic [31:0]              stall_cnt;
  logic [31:0]              fwd_cnt;

  modport master (
    output ex_valid, ex_we, ex_rd, ex_lat, ex_src, flush,
    input  fwd_sel, stall, stall_cnt, fwd_cnt
  );

  modport slave (
    input  ex_valid, ex_we, ex_rd, ex_lat, ex_src, flush,
    output fwd_sel, stall, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/fwd_port_match.sv
// Priority match of one EX source register against the shadow pipeline;
// the newest (lowest-numbered) matching stage wins.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  fwd_entry_t        stage_i [1:FWD_DEPTH],
  input  logic [REG_AW-1:0] src_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              hazard_o
);

  logic [ENTRY_RD_W-1:0] src_ext_s;
  logic                  win_found_s;
  logic                  win_rdy_s;
  logic [SEL_W-1:0]      win_sel_s;
  logic                  hit_s;

  assign src_ext_s = ENTRY_RD_W'(src_i);

  // Scan oldest to newest so the newest hit overwrites older ones
  always_comb begin
    sel_o       = SEL_W'(SEL_FORWARD_RAW);
    hazard_o    = 1'b0;
    win_found_s = 1'b0;
    win_rdy_s   = 1'b0;
    win_sel_s   = SEL_W'(SEL_FORWARD_RAW);
    hit_s       = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      hit_s       = stage_i[k].valid && (stage_i[k].rd == src_ext_s) && (src_i != '0);
      win_rdy_s   = hit_s ? (ENTRY_LAT_W'(k) >= stage_i[k].lat) : win_rdy_s;
      win_sel_s   = hit_s ? SEL_W'(stage_sel(k)) : win_sel_s;
      win_found_s = hit_s | win_found_s;
    end
    if (win_found_s && win_rdy_s) begin
      sel_o    = win_sel_s;
      hazard_o = 1'b0;
    end else if (win_found_s) begin
      sel_o    = SEL_W'(SEL_FORWARD_RAW);
      hazard_o = 1'b1;
    end else begin
      sel_o    = SEL_W'(SEL_FORWARD_RAW);
      hazard_o = 1'b0;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation from a shadow pipeline of
// in-flight destinations. Optional perf counters: define FWD_HAZARD_PERF_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_RD    = 2,
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input logic               clk,
  input logic               rst,
  fwd_hazard_unit_if.slave  bus
);

  fwd_entry_t              stage_q [1:FWD_DEPTH];
  fwd_entry_t              stage_d [1:FWD_DEPTH];
  fwd_entry_t              cap_s;
  logic [NUM_RD*SEL_W-1:0] fwd_sel_s;
  logic [NUM_RD-1:0]       hazard_s;
  logic                    stall_s;

  // Entry the EX instruction would leave behind in stage 1
  always_comb begin
    cap_s.valid = bus.ex_valid && bus.ex_we && (bus.ex_rd != '0);
    cap_s.rd    = ENTRY_RD_W'(bus.ex_rd);
    cap_s.lat   = clamp_lat(ENTRY_LAT_W'(bus.ex_lat), ENTRY_LAT_W'(FWD_DEPTH));
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    fwd_port_match #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .SEL_W     (SEL_W)
    ) u_match (
      .stage_i  (stage_q),
      .src_i    (bus.ex_src[i*REG_AW +: REG_AW]),
      .sel_o    (fwd_sel_s[i*SEL_W +: SEL_W]),
      .hazard_o (hazard_s[i])
    );
  end

  // Flush overrides stall: the killed instruction must not hold ID/EX
  assign stall_s     = (|hazard_s) && bus.ex_valid && !bus.flush;
  assign bus.stall   = stall_s;
  assign bus.fwd_sel = fwd_sel_s;

  // Shift the shadow pipeline; stage 1 takes a bubble on stall or flush
  always_comb begin
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      stage_d[k] = '0;
    end
    if (stall_s || bus.flush) begin
      stage_d[1] = '0;
    end else begin
      stage_d[1] = cap_s;
    end
    for (int k = 2; k <= FWD_DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Shadow pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic        fwd_any_s;

  assign fwd_any_s = bus.ex_valid && (fwd_sel_s != '0);

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (fwd_any_s && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end else begin
      fwd_cnt_d = fwd_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      fwd_cnt_q   <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.fwd_cnt   = 32'd0;
`endif

endmodule
